// File: rtl/intra_pkg.sv
`default_nettype none
// ============================================================================
// Package     : intra_pkg
// Description : Types and constants for the 4x4 luma intra neighbour fetcher:
//               picture-size defaults, the neutral sample, the read-index
//               enumeration, FSM state encoding and neighbour byte positions.
// Revision    : 1.0 - initial release
// ============================================================================
package intra_pkg;

  localparam int DEF_PIC_W_BLK = 320;
  localparam int DEF_PIC_H_BLK = 180;

  localparam logic [7:0] DEFAULT_SAMPLE = 8'd128;

  // Number of distinct reads one block can need (top, top-right, top-left, 4 left).
  localparam int NUM_RD = 7;

  // Neighbour byte positions: A..D top, E..H top-right, I..L left, M top-left.
  localparam int NUM_NB = 13;
  localparam int NB_A   = 0;
  localparam int NB_E   = 4;
  localparam int NB_I   = 8;
  localparam int NB_M   = 12;

  // Read index; its numeric value is also the bit position in the pending mask,
  // so the lowest pending bit is always the next read in issue order.
  typedef enum logic [2:0] {
    RD_TOP = 3'd0,
    RD_TR  = 3'd1,
    RD_TL  = 3'd2,
    RD_L0  = 3'd3,
    RD_L1  = 3'd4,
    RD_L2  = 3'd5,
    RD_L3  = 3'd6
  } rd_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Lowest set bit of the pending mask, returned as a read index.
  function automatic rd_idx_e first_pending(input logic [NUM_RD-1:0] mask);
    rd_idx_e idx;
    idx = RD_TOP;
    for (int i = NUM_RD - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = rd_idx_e'(3'(i));
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intra4x4_neighbour_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface   : intra4x4_neighbour_fetch_if
// Description : Read port of the reconstructed-picture line memory.
//               Ports : rd_en   - read strobe
//                       rd_addr - word address (pixel_row*PIC_W_BLK + block_col)
//                       rd_data - 4 pixels, leftmost in [7:0], valid the
//                                 cycle after rd_en
//               master = fetch engine, slave = memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface intra4x4_neighbour_fetch_if #(
  parameter int ADDR_W = 18
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface
`default_nettype wire

// File: rtl/intra4x4_nb_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : intra4x4_nb_addr_gen
// Description : Combinational word-address generator for one neighbour read.
//               Ports : bx_i   - block column
//                       by_i   - block row
//                       idx_i  - which neighbour read
//                       addr_o - row*PIC_W_BLK + col, at ADDR_W width
// Revision    : 1.0 - initial release
// ============================================================================
module intra4x4_nb_addr_gen
  import intra_pkg::*;
#(
  parameter int PIC_W_BLK = DEF_PIC_W_BLK,
  parameter int ADDR_W    = 18
) (
  input  logic [8:0]        bx_i,
  input  logic [7:0]        by_i,
  input  rd_idx_e           idx_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] c_PIC_W = ADDR_W'(PIC_W_BLK);
  localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] w_bx;
  logic [ADDR_W-1:0] w_by4;
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_bx  = ADDR_W'(bx_i);
  assign w_by4 = ADDR_W'({by_i, 2'b00});

  // Top-row reads use the last pixel row of the block above; left reads use
  // the column to the left on each of the block's own four rows.
  always_comb begin
    w_row = w_by4 - c_ONE;
    w_col = w_bx;
    case (idx_i)
      RD_TOP: w_col = w_bx;
      RD_TR:  w_col = w_bx + c_ONE;
      RD_TL:  w_col = w_bx - c_ONE;
      RD_L0: begin
        w_row = w_by4;
        w_col = w_bx - c_ONE;
      end
      RD_L1: begin
        w_row = w_by4 + ADDR_W'(1);
        w_col = w_bx - c_ONE;
      end
      RD_L2: begin
        w_row = w_by4 + ADDR_W'(2);
        w_col = w_bx - c_ONE;
      end
      RD_L3: begin
        w_row = w_by4 + ADDR_W'(3);
        w_col = w_bx - c_ONE;
      end
      default: begin
        w_row = w_by4 - c_ONE;
        w_col = w_bx;
      end
    endcase
  end

  assign addr_o = w_row * c_PIC_W + w_col;

endmodule
`default_nettype wire

// File: rtl/intra4x4_neighbour_fetch.sv
`default_nettype none
// ============================================================================
// Module      : intra4x4_neighbour_fetch
// Description : Fetches the 13 4x4 luma intra neighbours A..M of one block
//               from the recon line memory, with edge/availability
//               substitution, and presents them as registered bytes.
//               Ports : clk, reset       - clock, async active-high reset
//                       start_i          - request (sampled only in IDLE)
//                       bx_i, by_i       - block column / row
//                       tr_avail_i       - top-right block decoded
//                       mem              - memory read port (master)
//                       a_o .. m_o       - neighbour samples
//                       avail_*_o        - real-sample flags
//                       busy_o, done_o   - status / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module intra4x4_neighbour_fetch
  import intra_pkg::*;
#(
  parameter int PIC_W_BLK = DEF_PIC_W_BLK,
  parameter int PIC_H_BLK = DEF_PIC_H_BLK,
  parameter int ADDR_W    = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [8:0] bx_i,
  input  logic [7:0] by_i,
  input  logic       tr_avail_i,
  intra4x4_neighbour_fetch_if.master mem,
  output logic [7:0] a_o,
  output logic [7:0] b_o,
  output logic [7:0] c_o,
  output logic [7:0] d_o,
  output logic [7:0] e_o,
  output logic [7:0] f_o,
  output logic [7:0] g_o,
  output logic [7:0] h_o,
  output logic [7:0] i_o,
  output logic [7:0] j_o,
  output logic [7:0] k_o,
  output logic [7:0] l_o,
  output logic [7:0] m_o,
  output logic       avail_top_o,
  output logic       avail_left_o,
  output logic       avail_tl_o,
  output logic       busy_o,
  output logic       done_o
);

  state_e state_q, state_d;

  logic [8:0]        bx_q;
  logic [7:0]        by_q;
  logic [NUM_RD-1:0] pend_q;
  logic              top_q, left_q, tl_q, tr_q;
  logic              cap_vld_q;
  rd_idx_e           cap_idx_q;
  logic [7:0]        nb_q [NUM_NB];
  logic [7:0]        nb_d [NUM_NB];
  logic              av_top_q, av_left_q, av_tl_q;

  logic              w_start_ok;
  logic              w_top, w_left, w_tl, w_tr;
  rd_idx_e           w_idx;
  logic [NUM_RD-1:0] w_pend_nxt;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic              w_fin_entry;
  logic [7:0]        w_cap [NUM_NB];

  // --------------------------------------------------------------------------
  // Request qualification and availability
  // --------------------------------------------------------------------------
  assign w_start_ok = start_i && (32'(bx_i) < PIC_W_BLK) && (32'(by_i) < PIC_H_BLK);
  assign w_top      = (by_i != 8'd0);
  assign w_left     = (bx_i != 9'd0);
  assign w_tl       = w_top && w_left;
  assign w_tr       = w_top && tr_avail_i && ((32'(bx_i) + 32'd1) < PIC_W_BLK);

  assign w_idx      = first_pending(pend_q);
  assign w_pend_nxt = pend_q & ~(NUM_RD'(1) << w_idx);

  intra4x4_nb_addr_gen #(
    .PIC_W_BLK (PIC_W_BLK),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .bx_i   (bx_q),
    .by_i   (by_q),
    .idx_i  (w_idx),
    .addr_o (w_addr)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (w_start_ok) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // With nothing to read there is no data to drain, so go straight
        // to FINISH and keep the zero-read latency at two cycles.
        if (pend_q == '0) begin
          state_d = ST_FINISH;
        end else if (w_pend_nxt == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_en = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        w_rd_en = (pend_q != '0);
        busy_o  = 1'b1;
      end
      ST_DRAIN: busy_o = 1'b1;
      ST_FINISH: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        w_rd_en = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
      end
    endcase
  end

  assign mem.rd_en   = w_rd_en;
  assign mem.rd_addr = w_rd_en ? w_addr : '0;

  assign w_fin_entry = (state_d == ST_FINISH);

  // --------------------------------------------------------------------------
  // Capture mux: data returning this cycle belongs to the read tagged last cycle
  // --------------------------------------------------------------------------
  always_comb begin
    for (int n = 0; n < NUM_NB; n++) begin
      w_cap[n] = nb_q[n];
    end
    if (cap_vld_q) begin
      case (cap_idx_q)
        RD_TOP: begin
          for (int b = 0; b < 4; b++) begin
            w_cap[NB_A + b] = mem.rd_data[8*b +: 8];
          end
        end
        RD_TR: begin
          for (int b = 0; b < 4; b++) begin
            w_cap[NB_E + b] = mem.rd_data[8*b +: 8];
          end
        end
        RD_TL:   w_cap[NB_M]     = mem.rd_data[31:24];
        RD_L0:   w_cap[NB_I]     = mem.rd_data[31:24];
        RD_L1:   w_cap[NB_I + 1] = mem.rd_data[31:24];
        RD_L2:   w_cap[NB_I + 2] = mem.rd_data[31:24];
        RD_L3:   w_cap[NB_I + 3] = mem.rd_data[31:24];
        default: w_cap[NB_A]     = nb_q[NB_A];
      endcase
    end
  end

  // Substitution is applied on the edge into FINISH so it also sees a D that
  // is being captured on that same edge.
  always_comb begin
    for (int n = 0; n < NUM_NB; n++) begin
      nb_d[n] = w_cap[n];
    end
    if (w_fin_entry) begin
      if (!top_q) begin
        for (int n = NB_A; n < NB_I; n++) begin
          nb_d[n] = DEFAULT_SAMPLE;
        end
      end else if (!tr_q) begin
        for (int n = NB_E; n < NB_I; n++) begin
          nb_d[n] = w_cap[NB_A + 3];
        end
      end
      if (!left_q) begin
        for (int n = NB_I; n < NB_M; n++) begin
          nb_d[n] = DEFAULT_SAMPLE;
        end
      end
      if (!tl_q) begin
        nb_d[NB_M] = DEFAULT_SAMPLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx_q      <= '0;
      by_q      <= '0;
      pend_q    <= '0;
      top_q     <= 1'b0;
      left_q    <= 1'b0;
      tl_q      <= 1'b0;
      tr_q      <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= RD_TOP;
      av_top_q  <= 1'b0;
      av_left_q <= 1'b0;
      av_tl_q   <= 1'b0;
      for (int n = 0; n < NUM_NB; n++) begin
        nb_q[n] <= DEFAULT_SAMPLE;
      end
    end else begin
      cap_vld_q <= w_rd_en;
      if (w_rd_en) begin
        cap_idx_q <= w_idx;
      end
      if ((state_q == ST_IDLE) && w_start_ok) begin
        bx_q   <= bx_i;
        by_q   <= by_i;
        top_q  <= w_top;
        left_q <= w_left;
        tl_q   <= w_tl;
        tr_q   <= w_tr;
        pend_q <= {{4{w_left}}, w_tl, w_tr, w_top};
      end else if (w_rd_en) begin
        pend_q <= w_pend_nxt;
      end
      for (int n = 0; n < NUM_NB; n++) begin
        nb_q[n] <= nb_d[n];
      end
      // Flags move together with the bytes so both stay stable between dones.
      if (w_fin_entry) begin
        av_top_q  <= top_q;
        av_left_q <= left_q;
        av_tl_q   <= tl_q;
      end
    end
  end

  assign a_o = nb_q[0];
  assign b_o = nb_q[1];
  assign c_o = nb_q[2];
  assign d_o = nb_q[3];
  assign e_o = nb_q[4];
  assign f_o = nb_q[5];
  assign g_o = nb_q[6];
  assign h_o = nb_q[7];
  assign i_o = nb_q[8];
  assign j_o = nb_q[9];
  assign k_o = nb_q[10];
  assign l_o = nb_q[11];
  assign m_o = nb_q[12];

  assign avail_top_o  = av_top_q;
  assign avail_left_o = av_left_q;
  assign avail_tl_o   = av_tl_q;

endmodule
`default_nettype wire
